// File: rtl/rgb_pwm_sequencer_if.sv
// ============================================================================
//  Module      : rgb_pwm_sequencer_if
//  Description : Control and LED-pin bundle for the RGB PWM sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rgb_pwm_sequencer_if;
    logic       en;
    logic       mode;
    logic       LED_R;
    logic       LED_G;
    logic       LED_B;
    logic [2:0] color;
    logic       step_tick;

    modport master (
        output en, mode,
        input  LED_R, LED_G, LED_B, color, step_tick
    );

    modport slave (
        input  en, mode,
        output LED_R, LED_G, LED_B, color, step_tick
    );
endinterface

`default_nettype wire

// File: rtl/rgb_pwm_sequencer.sv
// ============================================================================
//  Module      : rgb_pwm_sequencer
//  Description : Cycles an active-low RGB LED through the seven non-black
//                colours, hard-stepped or faded with per-channel PWM.
//                Define RGB_PWM_SEQUENCER_GAMMA_EN for a squared (gamma)
//                brightness curve; linear when undefined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rgb_pwm_sequencer #(
    parameter int PWM_W           = 8,
    parameter int FRAMES_PER_STEP = 183,
    parameter int HOLD_STEPS      = 64
) (
    input  logic                clk,
    input  logic                rst,
    rgb_pwm_sequencer_if.slave  bus
);

    localparam int c_FRAME_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam int c_HOLD_W  = $clog2(HOLD_STEPS + 1);

    localparam logic [PWM_W-1:0]     c_MAX        = '1;
    localparam logic [PWM_W-1:0]     c_LVL_ONE    = PWM_W'(1);
    localparam logic [c_FRAME_W-1:0] c_FRAME_LAST = c_FRAME_W'(FRAMES_PER_STEP - 1);
    localparam logic [c_FRAME_W-1:0] c_FRAME_ONE  = c_FRAME_W'(1);
    localparam logic [c_HOLD_W-1:0]  c_HOLD_LAST  = c_HOLD_W'(HOLD_STEPS - 1);
    localparam logic [c_HOLD_W-1:0]  c_HOLD_ONE   = c_HOLD_W'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_STEP      = 3'd1,
        S_RAMP_UP   = 3'd2,
        S_HOLD      = 3'd3,
        S_RAMP_DOWN = 3'd4
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [PWM_W-1:0]     r_lvl, w_lvl_nxt;
    logic [PWM_W-1:0]     r_pwm, w_pwm_nxt;
    logic [c_FRAME_W-1:0] r_frame, w_frame_nxt;
    logic [c_HOLD_W-1:0]  r_hold, w_hold_nxt;
    logic                 r_mode, w_mode_nxt;
    logic [2:0]           r_color, w_color_nxt;
    logic                 r_step, w_step_nxt;
    logic [2:0]           r_led;

    logic                 w_running;
    logic                 w_tick;
    logic [2:0]           w_color_adv;
    logic [PWM_W-1:0]     w_lvl_eff;
    logic                 w_on;

    assign w_running   = (r_state != S_IDLE);
    assign w_tick      = w_running && (r_pwm == c_MAX) && (r_frame == c_FRAME_LAST);
    assign w_color_adv = (r_color == 3'd7) ? 3'd1 : r_color + 3'd1;

`ifdef RGB_PWM_SEQUENCER_GAMMA_EN
    logic [2*PWM_W-1:0] w_sq;
    assign w_sq      = {{PWM_W{1'b0}}, r_lvl} * {{PWM_W{1'b0}}, r_lvl};
    assign w_lvl_eff = w_sq[2*PWM_W-1:PWM_W];
`else
    assign w_lvl_eff = r_lvl;
`endif

    assign w_on = w_running && (r_pwm < w_lvl_eff);

    always_comb begin
        w_state_nxt = r_state;
        w_lvl_nxt   = r_lvl;
        w_hold_nxt  = r_hold;
        w_mode_nxt  = r_mode;
        w_color_nxt = r_color;
        w_step_nxt  = 1'b0;
        w_pwm_nxt   = r_pwm + c_LVL_ONE;
        w_frame_nxt = r_frame;
        if (r_pwm == c_MAX) begin
            w_frame_nxt = (r_frame == c_FRAME_LAST) ? '0 : r_frame + c_FRAME_ONE;
        end

        if (!bus.en) begin
            w_state_nxt = S_IDLE;
            w_lvl_nxt   = '0;
            w_pwm_nxt   = '0;
            w_frame_nxt = '0;
        end else begin
            w_step_nxt = w_tick;
            case (r_state)
                S_IDLE: begin
                    // Counters restart so the first tick lands a full period later
                    w_pwm_nxt   = '0;
                    w_frame_nxt = '0;
                    w_hold_nxt  = '0;
                    w_mode_nxt  = bus.mode;
                    w_state_nxt = bus.mode ? S_RAMP_UP : S_STEP;
                    w_lvl_nxt   = bus.mode ? '0 : c_MAX;
                end
                S_STEP: begin
                    w_lvl_nxt = c_MAX;
                    if (w_tick) begin
                        w_color_nxt = w_color_adv;
                        w_mode_nxt  = bus.mode;
                        if (bus.mode) begin
                            w_state_nxt = S_RAMP_UP;
                            w_lvl_nxt   = '0;
                        end
                    end
                end
                S_RAMP_UP: begin
                    if (w_tick) begin
                        w_lvl_nxt = r_lvl + c_LVL_ONE;
                        if (r_lvl == c_MAX - c_LVL_ONE) begin
                            w_state_nxt = S_HOLD;
                            w_hold_nxt  = '0;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_tick) begin
                        w_hold_nxt = r_hold + c_HOLD_ONE;
                        if (r_hold == c_HOLD_LAST) begin
                            w_state_nxt = S_RAMP_DOWN;
                        end
                    end
                end
                S_RAMP_DOWN: begin
                    if (w_tick) begin
                        w_lvl_nxt = r_lvl - c_LVL_ONE;
                        // Reaching zero ends this colour's dwell
                        if (r_lvl == c_LVL_ONE) begin
                            w_color_nxt = w_color_adv;
                            w_mode_nxt  = bus.mode;
                            w_state_nxt = bus.mode ? S_RAMP_UP : S_STEP;
                            w_lvl_nxt   = bus.mode ? '0 : c_MAX;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_lvl_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_lvl   <= '0;
            r_pwm   <= '0;
            r_frame <= '0;
            r_hold  <= '0;
            r_mode  <= 1'b0;
            r_color <= 3'd1;
            r_step  <= 1'b0;
            r_led   <= 3'b111;
        end else begin
            r_state <= w_state_nxt;
            r_lvl   <= w_lvl_nxt;
            r_pwm   <= w_pwm_nxt;
            r_frame <= w_frame_nxt;
            r_hold  <= w_hold_nxt;
            r_mode  <= w_mode_nxt;
            r_color <= w_color_nxt;
            r_step  <= w_step_nxt;
            r_led   <= ~(r_color & {3{w_on}});
        end
    end

    assign bus.LED_R     = r_led[0];
    assign bus.LED_G     = r_led[1];
    assign bus.LED_B     = r_led[2];
    assign bus.color     = r_color;
    assign bus.step_tick = r_step;

endmodule

`default_nettype wire
